sw_reg_rd: RTL and testbench
============================

// Module: sw_reg_rd
// PURPOSE
//   Wishbone-readable software register: fabric logic deposits a value that the processor reads back.
//   Counterpart of the write-direction software register.
//   - Captures fabric_data_in on a valid strobe and tracks unread (FRESH) and lost-sample (OVERFLOW) status.
//   - Exposes data, status and a small control word on a Wishbone classic slave port.
//   - Single clock domain: the fabric side is synchronous to wbs_clk_i.
// PARAMETERS
//   C_BASEADDR    32'h00000000  first byte address decoded by this slave
//   C_HIGHADDR    32'h0000FFFF  last byte address decoded by this slave
//   C_DATA_WIDTH  32            fabric data width, 1..32; zero-extended onto the bus
// PORTS
//   wbs_clk_i          in   1             single clock for the bus side and the fabric side
//   wbs_rst_i          in   1             synchronous, active-high reset
//   wbs_cyc_i          in   1             Wishbone cycle
//   wbs_stb_i          in   1             Wishbone strobe
//   wbs_we_i           in   1             1 = write, 0 = read
//   wbs_sel_i          in   4             byte selects (writes only)
//   wbs_adr_i          in   32            byte address
//   wbs_dat_i          in   32            write data
//   wbs_dat_o          out  32            read data, valid while ack is high
//   wbs_ack_o          out  1             transfer acknowledge
//   wbs_err_o          out  1             error: unmapped offset inside the address window
//   fabric_data_in     in   C_DATA_WIDTH  sample from fabric
//   fabric_data_valid  in   1             capture strobe, one cycle per sample
//   fabric_fresh       out  1             copy of STATUS.FRESH, so fabric can pace its writes
// BEHAVIOUR
//   Reset: all outputs 0; DATA 0, FRESH 0, OVERFLOW 0, OVF_CNT 0, FREEZE 0.
//   Address decode
//     - hit = cyc & stb & (C_BASEADDR <= adr <= C_HIGHADDR); off = adr - C_BASEADDR; off[1:0] ignored.
//     - Map: 0x0 DATA (RO); 0x4 STATUS (RO); 0x8 CONTROL (RW).
//     - STATUS layout: bit0 FRESH, bit1 OVERFLOW, [31:16] OVF_CNT.
//     - CONTROL layout: bit0 FREEZE; bit1 CLR_OVF, write-1 pulse, reads 0.
//   Bus handshake
//     - Accept cycle T: hit & ~ack & ~err.
//     - At the T+1 edge exactly one of ack/err rises, for exactly 1 cycle; 1-cycle latency.
//     - A strobe held high is therefore serviced every other cycle.
//     - A miss (address outside the window) never responds.
//   Read path
//     - dat_o is loaded at the T+1 edge from the register state as it stood during T, i.e. before any capture in T.
//     - dat_o returns to 0 when ack drops.
//   Side effects
//     - A DATA read clears FRESH at the T+1 edge.
//     - Writes to DATA or STATUS are acked with no effect.
//     - A CONTROL write with sel[0]=1 updates FREEZE; if dat_i[1]=1 it also clears OVERFLOW and OVF_CNT.
//     - A CONTROL write with sel[0]=0 is acked with no effect.
//     - Unmapped offset inside the window (0xC and up): err instead of ack; no side effects; dat_o 0.
//   Capture: on fabric_data_valid & ~FREEZE
//     - DATA <= zero-extended fabric_data_in; FRESH <= 1.
//     - If FRESH was 1 and no DATA read was accepted in the same cycle: OVERFLOW <= 1, OVF_CNT += 1.
//     - OVF_CNT saturates at 16'hFFFF and never wraps.
//     - Capture with a DATA read accepted in the same cycle: read returns the old value, FRESH ends at 1, no overflow.
//     - Capture with CLR_OVF in the same cycle: the clear wins; OVERFLOW 0, OVF_CNT 0.
//     - While FREEZE=1, valid strobes are ignored entirely: no capture, no overflow count.
//   Reset mid-transfer: the pending ack/err is dropped, nothing is committed, all state returns to reset values.
// TESTING
//   1. Reset, then read 0x0 and 0x4 -> both 0; ack 1 cycle after stb; err 0.
//   2. valid with data 0xEEEEEEEE, then read 0x4 -> 0x00000001.
//      Read 0x0 -> 0xEEEEEEEE; read 0x4 again -> 0x0; fabric_fresh falls with that ack.
//   3. Three valid strobes (0x1, 0x2, 0x3) with no read -> DATA 0x3, STATUS 0x00020003.
//      Write 0x8 = 0x2 -> STATUS 0x00000001.
//   4. Write 0x8 = 0x1 (FREEZE), then valid with 0xFFFFEEEE -> DATA unchanged, no overflow.
//      Write 0x8 = 0x0, then read 0x8 -> 0x0.
//   5. valid with 0xAAAA5555 in the same cycle a DATA read is accepted -> read returns the old DATA.
//      Then STATUS = 0x00000001 and DATA = 0xAAAA5555.
//   6. Read 0x10 -> err for 1 cycle, no ack. Read 0x00010000 -> no response.
//      Assert reset during a pending ack -> ack 0 next cycle.

Source files
------------

// File: rtl/sw_reg_rd.sv
// Wishbone-readable software register. Fabric logic deposits a sample that the
// processor reads back. FRESH flags an unread sample. OVERFLOW and OVF_CNT record
// samples that were overwritten before anyone read them.
module sw_reg_rd #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_FFFF,
  parameter int unsigned C_DATA_WIDTH = 32
) (
  input  logic                    wbs_clk_i,
  input  logic                    wbs_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic [31:0]             wbs_dat_o,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  input  logic [C_DATA_WIDTH-1:0] fabric_data_in,
  input  logic                    fabric_data_valid,
  output logic                    fabric_fresh
);

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_ACK,
    RSP_ERR
  } rsp_e;

  rsp_e        rsp_q, rsp_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] data_q, data_d;
  logic        fresh_q, fresh_d;
  logic        ovf_q, ovf_d;
  logic [15:0] cnt_q, cnt_d;
  logic        freeze_q, freeze_d;

  // Window checks use 33-bit differences. The borrow bit avoids comparisons that
  // collapse to constants when C_BASEADDR is 0 or C_HIGHADDR is all-ones.
  logic [32:0] lo_diff, hi_diff;
  logic [31:0] off;
  logic        hit, accept, mapped;
  logic        rd_data, ctrl_wr, capture;
  logic        unused_bits;

  assign lo_diff = {1'b0, wbs_adr_i} - {1'b0, C_BASEADDR};
  assign hi_diff = {1'b0, C_HIGHADDR} - {1'b0, wbs_adr_i};
  assign off     = lo_diff[31:0];
  assign hit     = wbs_cyc_i & wbs_stb_i & ~lo_diff[32] & ~hi_diff[32];
  assign accept  = hit & (rsp_q == RSP_IDLE);
  assign mapped  = (off[31:4] == 28'd0) && (off[3:2] != 2'b11);
  assign rd_data = accept & mapped & ~wbs_we_i & (off[3:2] == 2'b00);
  assign ctrl_wr = accept & mapped & wbs_we_i & (off[3:2] == 2'b10) & wbs_sel_i[0];
  assign capture = fabric_data_valid & ~freeze_q;

  assign unused_bits = ^{off[1:0], hi_diff[31:0], wbs_dat_i[31:2], wbs_sel_i[3:1]};

  // Register state, bus response and read-data holding register
  always_ff @(posedge wbs_clk_i) begin
    if (wbs_rst_i) begin
      rsp_q    <= RSP_IDLE;
      dat_q    <= '0;
      data_q   <= '0;
      fresh_q  <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      freeze_q <= 1'b0;
    end else begin
      rsp_q    <= rsp_d;
      dat_q    <= dat_d;
      data_q   <= data_d;
      fresh_q  <= fresh_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      freeze_q <= freeze_d;
    end
  end

  // Response selection, read mux, capture and status bookkeeping
  always_comb begin
    rsp_d    = RSP_IDLE;
    dat_d    = '0;
    data_d   = data_q;
    fresh_d  = fresh_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    freeze_d = freeze_q;

    if (accept) begin
      if (mapped) begin
        rsp_d = RSP_ACK;
        if (!wbs_we_i) begin
          unique case (off[3:2])
            2'b00:   dat_d = data_q;
            2'b01:   dat_d = {cnt_q, 14'd0, ovf_q, fresh_q};
            2'b10:   dat_d = {31'd0, freeze_q};
            default: dat_d = '0;
          endcase
        end
      end else begin
        rsp_d = RSP_ERR;
      end
    end

    if (ctrl_wr) begin
      freeze_d = wbs_dat_i[0];
    end

    // A capture in the same cycle as a DATA read leaves FRESH set. The reader
    // receives the previous sample, so the new one is still unread.
    if (capture) begin
      data_d  = 32'(fabric_data_in);
      fresh_d = 1'b1;
    end else if (rd_data) begin
      fresh_d = 1'b0;
    end

    if (ctrl_wr && wbs_dat_i[1]) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (capture && fresh_q && !rd_data) begin
      ovf_d = 1'b1;
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  assign wbs_ack_o    = (rsp_q == RSP_ACK);
  assign wbs_err_o    = (rsp_q == RSP_ERR);
  assign wbs_dat_o    = dat_q;
  assign fabric_fresh = fresh_q;

endmodule

// File: tb/tb_sw_reg_rd.sv
// Directed bench for sw_reg_rd. A vector table drives the main register
// behaviour. Hand-written sequences cover the same-cycle and multi-cycle cases.
module tb_sw_reg_rd;

  localparam int OP_RD = 0;
  localparam int OP_WR = 1;
  localparam int OP_VL = 2;

  typedef struct {
    int          op;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
    logic        exp_ack;
    logic        exp_err;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [31:0] dat_o;
  logic        ack, err;
  logic [31:0] fdata;
  logic        fvalid;
  logic        ffresh;

  int total = 0;
  int bad   = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sw_reg_rd #(
    .C_BASEADDR  (32'h0000_0000),
    .C_HIGHADDR  (32'h0000_FFFF),
    .C_DATA_WIDTH(32)
  ) dut (
    .wbs_clk_i        (clk),
    .wbs_rst_i        (rst),
    .wbs_cyc_i        (cyc),
    .wbs_stb_i        (stb),
    .wbs_we_i         (we),
    .wbs_sel_i        (sel),
    .wbs_adr_i        (adr),
    .wbs_dat_i        (wdat),
    .wbs_dat_o        (dat_o),
    .wbs_ack_o        (ack),
    .wbs_err_o        (err),
    .fabric_data_in   (fdata),
    .fabric_data_valid(fvalid),
    .fabric_fresh     (ffresh)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = '0; wdat = '0;
  endtask

  task automatic add(input int op, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] e, input logic ea,
                     input logic ee, input string n);
    vec_t v;
    v.op = op; v.adr = a; v.dat = d; v.sel = s; v.exp = e;
    v.exp_ack = ea; v.exp_err = ee; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic pulse_valid(input logic [31:0] d);
    @(negedge clk);
    fvalid = 1; fdata = d;
    @(negedge clk);
    fvalid = 0;
  endtask

  // One bus transfer. Response is sampled 1 time unit after the accepting edge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd,
                     output logic a_o, output logic e_o);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk);
    #1;
    rd = dat_o; a_o = ack; e_o = err;
    @(negedge clk);
    idle_bus();
  endtask

  initial begin
    logic [31:0] rd;
    logic        a_o, e_o;
    logic [3:0]  held_exp;

    rst = 1; fvalid = 0; fdata = '0;
    idle_bus();

    // Reset and basic reads
    add(OP_RD, 32'h0, 0, 4'hF, 32'h0, 1, 0, "rst_data");
    add(OP_RD, 32'h4, 0, 4'hF, 32'h0, 1, 0, "rst_status");
    // Single capture, then read clears FRESH
    add(OP_VL, 0, 32'hEEEE_EEEE, 0, 0, 0, 0, "vl_e");
    add(OP_RD, 32'h4, 0, 4'hF, 32'h0000_0001, 1, 0, "st_fresh");
    add(OP_RD, 32'h0, 0, 4'hF, 32'hEEEE_EEEE, 1, 0, "data_e");
    add(OP_RD, 32'h4, 0, 4'hF, 32'h0000_0000, 1, 0, "st_cleared");
    // Overflow counting and clear
    add(OP_VL, 0, 32'h1, 0, 0, 0, 0, "vl_1");
    add(OP_VL, 0, 32'h2, 0, 0, 0, 0, "vl_2");
    add(OP_VL, 0, 32'h3, 0, 0, 0, 0, "vl_3");
    add(OP_RD, 32'h4, 0, 4'hF, 32'h0002_0003, 1, 0, "st_ovf2");
    add(OP_WR, 32'h8, 32'h2, 4'hF, 0, 1, 0, "wr_clr");
    add(OP_RD, 32'h4, 0, 4'hF, 32'h0000_0001, 1, 0, "st_after_clr");
    add(OP_RD, 32'h8, 0, 4'hF, 32'h0, 1, 0, "ctrl_clr_reads0");
    add(OP_RD, 32'h0, 0, 4'hF, 32'h3, 1, 0, "data_3");
    // Writes to read-only registers do nothing
    add(OP_WR, 32'h0, 32'h5555_5555, 4'hF, 0, 1, 0, "wr_data_ro");
    add(OP_WR, 32'h4, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, "wr_stat_ro");
    add(OP_RD, 32'h0, 0, 4'hF, 32'h3, 1, 0, "data_ro_kept");
    add(OP_RD, 32'h4, 0, 4'hF, 32'h0, 1, 0, "stat_ro_kept");
    // CONTROL write without sel[0] is ignored
    add(OP_WR, 32'h8, 32'h1, 4'hE, 0, 1, 0, "wr_ctrl_nosel");
    add(OP_RD, 32'h8, 0, 4'hF, 32'h0, 1, 0, "ctrl_nosel");
    // FREEZE blocks capture
    add(OP_WR, 32'h8, 32'h1, 4'h1, 0, 1, 0, "wr_freeze");
    add(OP_RD, 32'h8, 0, 4'hF, 32'h1, 1, 0, "ctrl_freeze");
    add(OP_VL, 0, 32'hFFFF_EEEE, 0, 0, 0, 0, "vl_frozen");
    add(OP_RD, 32'h4, 0, 4'hF, 32'h0, 1, 0, "st_frozen");
    add(OP_RD, 32'h0, 0, 4'hF, 32'h3, 1, 0, "data_frozen");
    add(OP_WR, 32'h8, 32'h0, 4'hF, 0, 1, 0, "wr_unfreeze");
    add(OP_RD, 32'h8, 0, 4'hF, 32'h0, 1, 0, "ctrl_unfrozen");
    // Unmapped offsets give err with no side effect
    add(OP_RD, 32'h10, 0, 4'hF, 32'h0, 0, 1, "rd_unmapped");
    add(OP_RD, 32'hC, 0, 4'hF, 32'h0, 0, 1, "rd_0c");
    add(OP_WR, 32'hC, 32'h1, 4'hF, 0, 0, 1, "wr_0c");
    add(OP_RD, 32'h8, 0, 4'hF, 32'h0, 1, 0, "ctrl_after_err");

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_dat", dat_o, 0);
    check("rst_fresh", {31'd0, ffresh}, 0);
    @(negedge clk);
    rst = 0;

    foreach (vecs[i]) begin
      if (vecs[i].op == OP_VL) begin
        pulse_valid(vecs[i].dat);
      end else begin
        bus(vecs[i].op == OP_WR, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, a_o, e_o);
        check({vecs[i].name, "_ack"}, {31'd0, a_o}, {31'd0, vecs[i].exp_ack});
        check({vecs[i].name, "_err"}, {31'd0, e_o}, {31'd0, vecs[i].exp_err});
        if (vecs[i].op == OP_RD) check(vecs[i].name, rd, vecs[i].exp);
        // The response lasts one cycle and read data returns to 0
        @(posedge clk);
        #1;
        check({vecs[i].name, "_drop"}, {30'd0, ack, err}, 0);
        check({vecs[i].name, "_dat0"}, dat_o, 0);
      end
    end

    // fabric_fresh follows FRESH and falls together with the DATA read ack
    pulse_valid(32'h1234_5678);
    #1;
    check("ffresh_set", {31'd0, ffresh}, 1);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h0;
    @(posedge clk);
    #1;
    check("ffresh_ack", {31'd0, ack}, 1);
    check("ffresh_fall", {31'd0, ffresh}, 0);
    @(negedge clk);
    idle_bus();

    // Capture in the same cycle as an accepted DATA read
    pulse_valid(32'h1234_5678);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h0;
    fvalid = 1; fdata = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    check("race_old", dat_o, 32'h1234_5678);
    @(negedge clk);
    idle_bus(); fvalid = 0;
    bus(0, 32'h4, 0, 4'hF, rd, a_o, e_o);
    check("race_status", rd, 32'h0000_0001);
    bus(0, 32'h0, 0, 4'hF, rd, a_o, e_o);
    check("race_data", rd, 32'hAAAA_5555);

    // Capture colliding with CLR_OVF: the clear wins
    pulse_valid(32'h11);
    pulse_valid(32'h22);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h8; wdat = 32'h2; sel = 4'h1;
    fvalid = 1; fdata = 32'h33;
    @(negedge clk);
    idle_bus(); fvalid = 0;
    bus(0, 32'h4, 0, 4'hF, rd, a_o, e_o);
    check("clr_wins", rd, 32'h0000_0001);
    bus(0, 32'h0, 0, 4'hF, rd, a_o, e_o);
    check("clr_data", rd, 32'h33);

    // A held strobe is serviced every other cycle
    held_exp = 4'b0101;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h4;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("held_ack%0d", k), {31'd0, ack}, {31'd0, held_exp[k]});
    end
    @(negedge clk);
    idle_bus();

    // An address outside the window never responds
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h0001_0000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("miss%0d", k), {30'd0, ack, err}, 0);
    end
    @(negedge clk);
    idle_bus();

    // Reset while an ack is pending drops it and clears state
    pulse_valid(32'h77);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h0; rst = 1;
    @(posedge clk);
    #1;
    check("rst_pending_ack", {31'd0, ack}, 0);
    check("rst_pending_fresh", {31'd0, ffresh}, 0);
    @(negedge clk);
    idle_bus(); rst = 0;
    bus(0, 32'h0, 0, 4'hF, rd, a_o, e_o);
    check("rst_mid_data", rd, 0);
    check("rst_mid_ack", {31'd0, a_o}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
